// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, default datapath width and FSM state type.
// Used by the ALU control stage and by alu_iterative.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [3:0] OP_DIV = 4'b0000;
  localparam logic [3:0] OP_MUL = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LT  = 4'b0110;
  localparam logic [3:0] OP_LE  = 4'b0111;
  localparam logic [3:0] OP_GT  = 4'b1000;
  localparam logic [3:0] OP_GE  = 4'b1001;
  localparam logic [3:0] OP_EQ  = 4'b1010;
  localparam logic [3:0] OP_NE  = 4'b1011;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} alu_state_t;

endpackage

// File: rtl/muldiv_iter.sv
// One-bit-per-step iteration datapath: unsigned shift-add multiply and restoring divide.
// {hi,lo} ends as the product (mult) or remainder/quotient (div) after WIDTH steps.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] m;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  always_comb begin
    sum     = {1'b0, hi} + {1'b0, m};
    shifted = {hi, lo[WIDTH-1]};
    diff    = shifted - {1'b0, m};
    if (is_div) begin
      // Restoring step: keep the trial subtraction only when it does not go negative.
      if (shifted >= {1'b0, m}) begin
        hi_next = diff[WIDTH-1:0];
        lo_next = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_next = shifted[WIDTH-1:0];
        lo_next = {lo[WIDTH-2:0], 1'b0};
      end
    end else if (lo[0]) begin
      hi_next = sum[WIDTH:1];
      lo_next = {sum[0], lo[WIDTH-1:1]};
    end else begin
      hi_next = {1'b0, hi[WIDTH-1:1]};
      lo_next = {hi[0], lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      hi <= '0;
      lo <= a;
      m  <= b;
    end else if (step) begin
      hi <= hi_next;
      lo <= lo_next;
    end
  end

endmodule

// File: rtl/alu_iterative.sv
// Iterative ALU: single-cycle logic/arith/compare ops plus WIDTH-cycle multiply and divide,
// sequenced by an IDLE/MUL/DIV/DONE FSM with a one-cycle Done pulse.
module alu_iterative
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [3:0]       ALU_Control,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Result_Hi,
  output logic             Zero,
  output logic             Busy,
  output logic             Done,
  output logic             Div_Zero,
  output logic             Invalid
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  alu_state_t        state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              md_load, md_step;
  logic [WIDTH-1:0]  md_hi, md_lo;
  logic [WIDTH-1:0]  sc_result;
  logic              sc_valid;
  logic signed [WIDTH-1:0] sa, sb;
  logic [WIDTH-1:0]  res_next, res_hi_next;
  logic              zero_next, dz_next, inv_next;

  function automatic logic [WIDTH-1:0] flag_word(input logic f);
    return {{(WIDTH-1){1'b0}}, f};
  endfunction

  assign sa = A;
  assign sb = B;

  always_comb begin
    sc_valid  = 1'b1;
    sc_result = '0;
    case (ALU_Control)
      OP_SUB:  sc_result = A - B;
      OP_ADD:  sc_result = A + B;
      OP_OR:   sc_result = A | B;
      OP_AND:  sc_result = A & B;
      OP_LT:   sc_result = flag_word(sa <  sb);
      OP_LE:   sc_result = flag_word(sa <= sb);
      OP_GT:   sc_result = flag_word(sa >  sb);
      OP_GE:   sc_result = flag_word(sa >= sb);
      OP_EQ:   sc_result = flag_word(sa == sb);
      OP_NE:   sc_result = flag_word(sa != sb);
      default: sc_valid  = 1'b0;
    endcase
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk     (Clk),
    .load    (md_load),
    .step    (md_step),
    .is_div  (state == DIV),
    .a       (A),
    .b       (B),
    .hi_next (md_hi),
    .lo_next (md_lo)
  );

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    md_load     = 1'b0;
    md_step     = 1'b0;
    res_next    = Result;
    res_hi_next = Result_Hi;
    zero_next   = Zero;
    dz_next     = Div_Zero;
    inv_next    = Invalid;
    Busy        = 1'b0;
    Done        = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          dz_next  = 1'b0;
          inv_next = 1'b0;
          if (ALU_Control == OP_MUL || (ALU_Control == OP_DIV && B != '0)) begin
            md_load    = 1'b1;
            cnt_next   = '0;
            state_next = (ALU_Control == OP_MUL) ? MUL : DIV;
          end else if (ALU_Control == OP_DIV) begin
            res_next    = '1;
            res_hi_next = A;
            zero_next   = 1'b0;
            dz_next     = 1'b1;
            state_next  = DONE;
          end else begin
            res_next    = sc_valid ? sc_result : '0;
            res_hi_next = '0;
            zero_next   = (res_next == '0);
            inv_next    = ~sc_valid;
            state_next  = DONE;
          end
        end
      end
      MUL, DIV: begin
        Busy     = 1'b1;
        md_step  = 1'b1;
        cnt_next = cnt + CNT_W'(1);
        // The final step's outputs are captured straight from the datapath.
        if (cnt == LAST_STEP) begin
          res_next    = md_lo;
          res_hi_next = md_hi;
          zero_next   = (md_lo == '0);
          state_next  = DONE;
        end
      end
      DONE: begin
        Done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Result    <= '0;
      Result_Hi <= '0;
      Zero      <= 1'b0;
      Div_Zero  <= 1'b0;
      Invalid   <= 1'b0;
    end else begin
      Result    <= res_next;
      Result_Hi <= res_hi_next;
      Zero      <= zero_next;
      Div_Zero  <= dz_next;
      Invalid   <= inv_next;
    end
  end

endmodule

// File: tb/tb_alu_iterative.sv
// Bench for alu_iterative: directed cases plus random ops checked against an arithmetic model.
module tb_alu_iterative;

  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Rst_n = 1'b0;
  logic         Start = 1'b0;
  logic [3:0]   ALU_Control = 4'd0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] Result, Result_Hi;
  logic         Zero, Busy, Done, Div_Zero, Invalid;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  alu_iterative #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .ALU_Control(ALU_Control),
    .A(A), .B(B), .Result(Result), .Result_Hi(Result_Hi), .Zero(Zero),
    .Busy(Busy), .Done(Done), .Div_Zero(Div_Zero), .Invalid(Invalid)
  );

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         dz;
    logic         inv;
    logic [7:0]   lat;
  } exp_t;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] bit_word(input logic f);
    logic [W-1:0] r;
    r = '0;
    r[0] = f;
    return r;
  endfunction

  function automatic exp_t model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [2*W-1:0] p;
    e = '0;
    e.lat = 8'd1;
    case (c)
      4'd0: if (b == 0) begin
              e.res = '1; e.hi = a; e.dz = 1'b1;
            end else begin
              e.res = a / b; e.hi = a % b; e.lat = 8'(W + 1);
            end
      4'd1: begin
              p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
              e.hi = p[2*W-1:W]; e.res = p[W-1:0]; e.lat = 8'(W + 1);
            end
      4'd2:  e.res = a - b;
      4'd3:  e.res = a + b;
      4'd4:  e.res = a | b;
      4'd5:  e.res = a & b;
      4'd6:  e.res = bit_word($signed(a) <  $signed(b));
      4'd7:  e.res = bit_word($signed(a) <= $signed(b));
      4'd8:  e.res = bit_word($signed(a) >  $signed(b));
      4'd9:  e.res = bit_word($signed(a) >= $signed(b));
      4'd10: e.res = bit_word(a == b);
      4'd11: e.res = bit_word(a != b);
      default: e.inv = 1'b1;
    endcase
    return e;
  endfunction

  // Issue one op from IDLE, optionally scrambling inputs and Start while it runs.
  task automatic run_op(input string tag, input logic [3:0] c, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit disturb);
    exp_t e;
    int lat, busy_n;
    e = model(c, a, b);
    ALU_Control = c; A = a; B = b; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    lat = 1;
    busy_n = 0;
    while (!Done && lat < 200) begin
      if (Busy) busy_n++;
      if (disturb) begin
        A = $urandom; B = $urandom; ALU_Control = 4'($urandom); Start = 1'($urandom);
      end
      @(posedge Clk); #1;
      lat++;
    end
    check({tag, " done"}, W'(Done), W'(1));
    check({tag, " latency"}, W'(lat), W'(e.lat));
    check({tag, " busy_cycles"}, W'(busy_n), W'(e.lat) - W'(1));
    check({tag, " busy_at_done"}, W'(Busy), W'(0));
    check({tag, " result"}, Result, e.res);
    check({tag, " result_hi"}, Result_Hi, e.hi);
    check({tag, " zero"}, W'(Zero), W'(e.res == 0));
    check({tag, " div_zero"}, W'(Div_Zero), W'(e.dz));
    check({tag, " invalid"}, W'(Invalid), W'(e.inv));
    @(posedge Clk); #1;
    Start = 1'b0;
    check({tag, " done_pulse"}, W'(Done), W'(0));
    check({tag, " hold"}, Result, e.res);
  endtask

  initial begin
    logic [3:0]   c;
    logic [W-1:0] a, b;

    #2;
    check("reset result", Result, '0);
    check("reset result_hi", Result_Hi, '0);
    check("reset flags", {27'd0, Zero, Busy, Done, Div_Zero, Invalid}, '0);
    @(posedge Clk); #1;
    Rst_n = 1'b1;

    run_op("add", 4'b0011, 32'd7, 32'd5, 1'b0);
    run_op("sub_zero", 4'b0010, 32'd42, 32'd42, 1'b0);
    run_op("mul", 4'b0001, 32'hFFFF_FFFF, 32'd2, 1'b1);
    run_op("div", 4'b0000, 32'd100, 32'd7, 1'b1);
    run_op("div0", 4'b0000, 32'd100, 32'd0, 1'b0);
    run_op("lt_neg", 4'b0110, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op("lt_edge", 4'b0110, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
    run_op("gt_edge", 4'b1000, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
    run_op("eq", 4'b1010, 32'd9, 32'd9, 1'b0);
    run_op("invalid", 4'b1111, 32'd3, 32'd4, 1'b0);
    run_op("mul_big", 4'b0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run_op("div_small", 4'b0000, 32'd5, 32'd9, 1'b0);

    // Reset in the middle of a divide: nothing completes and outputs clear at once.
    ALU_Control = 4'b0000; A = 32'd1000; B = 32'd7; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (9) begin @(posedge Clk); #1; end
    check("mid busy", W'(Busy), W'(1));
    Rst_n = 1'b0;
    #1;
    check("async result", Result, '0);
    check("async result_hi", Result_Hi, '0);
    check("async flags", {27'd0, Zero, Busy, Done, Div_Zero, Invalid}, '0);
    repeat (3) begin
      @(posedge Clk); #1;
      check("rst no_done", W'(Done | Busy), W'(0));
    end
    Rst_n = 1'b1;
    run_op("after_rst", 4'b0101, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0);

    repeat (40) begin
      c = 4'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 6) == 0) ? '0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      run_op("random", c, a, b, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
